// File: rtl/quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// quad_encoder_counter
//
// Purpose:
//   Converts the debounced, clock-synchronous A/B phases of a mechanical rotary
//   encoder into a bounded up/down count. Only complete, valid quadrature
//   cycles that end back at the 00 rest position count as a detent. Partial
//   wiggles and illegal jumps never move the count.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   enc_a       in   debounced encoder phase A (synchronous to clk)
//   enc_b       in   debounced encoder phase B (synchronous to clk)
//   value       out  [WIDTH-1:0] registered count
//   step_pulse  out  one-cycle pulse per detected detent
//   dir         out  direction of last detent (1 = up, 0 = down), held
//   err         out  one-cycle pulse when both phases change in one cycle
//
// Parameters:
//   WIDTH     width of value
//   INIT      value loaded on reset (<= 2**WIDTH-1)
//   STEP      amount added/subtracted per detent (1 .. 2**WIDTH-1)
//   SATURATE  1 = clamp at 0 and 2**WIDTH-1, 0 = wrap modulo 2**WIDTH
// -----------------------------------------------------------------------------
module quad_encoder_counter #(
  parameter int          WIDTH    = 8,
  parameter int unsigned INIT     = 0,
  parameter int unsigned STEP     = 1,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] value,
  output logic             step_pulse,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]   MAX_X  = {1'b0, {WIDTH{1'b1}}};

  // Registered state
  logic [WIDTH-1:0]   value_q,  value_d;
  logic               step_q,   step_d;
  logic               dir_q,    dir_d;
  logic               err_q,    err_d;
  logic signed [3:0]  acc_q,    acc_d;
  logic [1:0]         prev_q,   prev_d;
  logic               primed_q, primed_d;

  // Combinational helpers
  logic [1:0]         phase;
  logic [1:0]         delta;
  logic signed [3:0]  acc_step;
  logic [WIDTH:0]     sum_x;
  logic [WIDTH:0]     diff_x;
  logic [WIDTH-1:0]   up_v;
  logic [WIDTH-1:0]   dn_v;

  always_comb begin
    // Gray index {a,b}: 00->0, 01->1, 11->2, 10->3 is exactly {a, a^b}.
    phase = {enc_a, enc_a ^ enc_b};
    // Modulo-4 difference falls out of 2-bit wrap-around subtraction.
    delta = phase - prev_q;

    // Saturating/wrapping arithmetic in WIDTH+1 bits: the extra bit is the
    // carry on the way up and the borrow on the way down.
    sum_x  = {1'b0, value_q} + STEP_X;
    diff_x = {1'b0, value_q} - STEP_X;
    up_v   = (SATURATE && (sum_x > MAX_X)) ? MAX_X[WIDTH-1:0] : sum_x[WIDTH-1:0];
    dn_v   = (SATURATE && diff_x[WIDTH])   ? '0               : diff_x[WIDTH-1:0];

    acc_step = acc_q;
    case (delta)
      2'd1:    acc_step = acc_q + 4'sd1;
      2'd3:    acc_step = acc_q - 4'sd1;
      default: acc_step = acc_q;
    endcase
  end

  always_comb begin
    value_d  = value_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = 1'b0;
    acc_d    = acc_q;
    prev_d   = prev_q;
    primed_d = primed_q;

    if (!primed_q) begin
      // First edge after reset only captures the resting phase, so inputs
      // parked off the 00 position never produce a spurious count.
      prev_d   = phase;
      primed_d = 1'b1;
    end else begin
      prev_d = phase;
      if (delta == 2'd2) begin
        // Both phases flipped together: direction unknown, keep acc as is.
        err_d = 1'b1;
      end else if (delta != 2'd0) begin
        acc_d = acc_step;
        if (phase == 2'd0) begin
          // Back at rest: a full cycle is exactly four net quarter steps.
          acc_d = '0;
          if (acc_step == 4'sd4) begin
            step_d  = 1'b1;
            dir_d   = 1'b1;
            value_d = up_v;
          end else if (acc_step == -4'sd4) begin
            step_d  = 1'b1;
            dir_d   = 1'b0;
            value_d = dn_v;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= INIT_V;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      value_q  <= value_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      prev_q   <= prev_d;
      primed_q <= primed_d;
    end
  end

  assign value      = value_q;
  assign step_pulse = step_q;
  assign dir        = dir_q;
  assign err        = err_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_counter
//
// Three instances share one stimulus stream:
//   dut 0: INIT=0,   STEP=1,  SATURATE=1
//   dut 1: INIT=250, STEP=16, SATURATE=1
//   dut 2: INIT=250, STEP=16, SATURATE=0
// A behavioural model tracks rotation as signed quarter-turn counts and pushes
// expected outputs into exp_q every cycle; a segment table holds hand-derived
// results for dut 0, and a hand-written sequence covers clamp/wrap limits.
// -----------------------------------------------------------------------------
module tb_quad_encoder_counter;

  localparam int W = 11;  // {value[7:0], step_pulse, dir, err}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] val_w  [3];
  logic       step_w [3];
  logic       dir_w  [3];
  logic       err_w  [3];

  quad_encoder_counter #(.WIDTH(8), .INIT(0), .STEP(1), .SATURATE(1'b1)) u_dut0 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(val_w[0]), .step_pulse(step_w[0]), .dir(dir_w[0]), .err(err_w[0])
  );
  quad_encoder_counter #(.WIDTH(8), .INIT(250), .STEP(16), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(val_w[1]), .step_pulse(step_w[1]), .dir(dir_w[1]), .err(err_w[1])
  );
  quad_encoder_counter #(.WIDTH(8), .INIT(250), .STEP(16), .SATURATE(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .value(val_w[2]), .step_pulse(step_w[2]), .dir(dir_w[2]), .err(err_w[2])
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Position on the detent circle as a rest-relative quarter-turn count.
  int p_init [3] = '{0, 250, 250};
  int p_step [3] = '{1, 16, 16};
  bit p_sat  [3] = '{1'b1, 1'b1, 1'b0};

  int m_val [3];
  int m_acc [3];
  int m_prev[3];
  bit m_primed[3];
  bit m_step[3];
  bit m_dir [3];
  bit m_err [3];

  function automatic int pos_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int pos);
    case (pos)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic model_step(input logic r, input logic [1:0] ab);
    int p;
    int d;
    int v;
    p = pos_of(ab);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_val[k] = p_init[k]; m_acc[k] = 0; m_prev[k] = 0; m_primed[k] = 0;
        m_step[k] = 0; m_dir[k] = 0; m_err[k] = 0;
      end else if (!m_primed[k]) begin
        m_prev[k] = p; m_primed[k] = 1; m_step[k] = 0; m_err[k] = 0;
      end else begin
        d = (p - m_prev[k] + 4) % 4;
        m_prev[k] = p;
        m_step[k] = 0;
        m_err[k]  = 0;
        if (d == 2) begin
          m_err[k] = 1;
        end else if (d != 0) begin
          m_acc[k] += (d == 1) ? 1 : -1;
          // 4-bit signed accumulator range
          if (m_acc[k] > 7)  m_acc[k] -= 16;
          if (m_acc[k] < -8) m_acc[k] += 16;
          if (p == 0) begin
            if (m_acc[k] == 4 || m_acc[k] == -4) begin
              m_step[k] = 1;
              m_dir[k]  = (m_acc[k] == 4);
              v = m_dir[k] ? m_val[k] + p_step[k] : m_val[k] - p_step[k];
              if (p_sat[k]) begin
                if (v > 255) v = 255;
                if (v < 0)   v = 0;
              end else begin
                v = (v + 256) % 256;
              end
              m_val[k] = v;
            end
            m_acc[k] = 0;
          end
        end
      end
      exp_q.push_back({8'(m_val[k]), m_step[k], m_dir[k], m_err[k]});
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic [1:0] ab);
    logic [W-1:0] e;
    @(negedge clk);
    reset = r;
    enc_a = ab[1];
    enc_b = ab[0];
    model_step(r, ab);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      check($sformatf("value[%0d]", k), 32'(val_w[k]),  32'(e[10:3]));
      check($sformatf("step[%0d]", k),  32'(step_w[k]), 32'(e[2]));
      check($sformatf("dir[%0d]", k),   32'(dir_w[k]),  32'(e[1]));
      check($sformatf("err[%0d]", k),   32'(err_w[k]),  32'(e[0]));
    end
  endtask

  task automatic fwd();
    drive(1'b0, 2'b01); drive(1'b0, 2'b11); drive(1'b0, 2'b10); drive(1'b0, 2'b00);
  endtask

  task automatic rev();
    drive(1'b0, 2'b10); drive(1'b0, 2'b11); drive(1'b0, 2'b01); drive(1'b0, 2'b00);
  endtask

  // ---------------- segment table (dut 0 expectations) ----------------
  typedef struct {
    logic       rst;
    logic [1:0] ab;
    int         hold;
    int         e_val;
    logic       e_dir;
    int         e_steps;
    int         e_errs;
  } seg_t;

  seg_t tbl[$];

  function automatic void add(input logic rst, input logic [1:0] ab, input int hold,
                              input int e_val, input logic e_dir, input int e_steps,
                              input int e_errs);
    seg_t s;
    s.rst = rst; s.ab = ab; s.hold = hold; s.e_val = e_val;
    s.e_dir = e_dir; s.e_steps = e_steps; s.e_errs = e_errs;
    tbl.push_back(s);
  endfunction

  // ---------------- main ----------------
  initial begin
    int steps;
    int errs;
    int cur;
    int r;
    int e_v0[5] = '{1, 2, 1, 0, 0};
    int e_v1[5] = '{255, 255, 239, 223, 207};
    int e_v2[5] = '{10, 26, 10, 250, 234};

    // reset
    add(1'b1, 2'b00, 2, 0, 1'b0, 0, 0);
    // full forward cycle, 3 cycles per position
    add(1'b0, 2'b00, 3, 0, 1'b0, 0, 0);
    add(1'b0, 2'b01, 3, 0, 1'b0, 0, 0);
    add(1'b0, 2'b11, 3, 0, 1'b0, 0, 0);
    add(1'b0, 2'b10, 3, 0, 1'b0, 0, 0);
    add(1'b0, 2'b00, 3, 1, 1'b1, 1, 0);
    // partial wiggle: no count
    add(1'b0, 2'b01, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b11, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b01, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b00, 2, 1, 1'b1, 0, 0);
    // following full forward increments by exactly 1
    add(1'b0, 2'b01, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b11, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b10, 2, 1, 1'b1, 0, 0);
    add(1'b0, 2'b00, 2, 2, 1'b1, 1, 0);
    // illegal jump 00 -> 11, then 10 -> 00: one err, no count
    add(1'b0, 2'b11, 2, 2, 1'b1, 0, 1);
    add(1'b0, 2'b10, 2, 2, 1'b1, 0, 0);
    add(1'b0, 2'b00, 2, 2, 1'b1, 0, 0);
    // recovery: 01 held one cycle, then normal count
    add(1'b0, 2'b01, 1, 2, 1'b1, 0, 0);
    add(1'b0, 2'b11, 2, 2, 1'b1, 0, 0);
    add(1'b0, 2'b10, 2, 2, 1'b1, 0, 0);
    add(1'b0, 2'b00, 2, 3, 1'b1, 1, 0);
    // two more forward detents up to 5
    add(1'b0, 2'b01, 1, 3, 1'b1, 0, 0);
    add(1'b0, 2'b11, 1, 3, 1'b1, 0, 0);
    add(1'b0, 2'b10, 1, 3, 1'b1, 0, 0);
    add(1'b0, 2'b00, 1, 4, 1'b1, 1, 0);
    add(1'b0, 2'b01, 1, 4, 1'b1, 0, 0);
    add(1'b0, 2'b11, 1, 4, 1'b1, 0, 0);
    add(1'b0, 2'b10, 1, 4, 1'b1, 0, 0);
    add(1'b0, 2'b00, 1, 5, 1'b1, 1, 0);
    // reverse detent 5 -> 4
    add(1'b0, 2'b10, 2, 5, 1'b1, 0, 0);
    add(1'b0, 2'b11, 2, 5, 1'b1, 0, 0);
    add(1'b0, 2'b01, 2, 5, 1'b1, 0, 0);
    add(1'b0, 2'b00, 2, 4, 1'b0, 1, 0);
    // reset mid-rotation, release resting at 10, then 10 -> 00: no count
    add(1'b0, 2'b01, 2, 4, 1'b0, 0, 0);
    add(1'b0, 2'b11, 2, 4, 1'b0, 0, 0);
    add(1'b1, 2'b11, 2, 0, 1'b0, 0, 0);
    add(1'b0, 2'b10, 3, 0, 1'b0, 0, 0);
    add(1'b0, 2'b00, 3, 0, 1'b0, 0, 0);
    // then a full forward cycle gives INIT+STEP
    add(1'b0, 2'b01, 2, 0, 1'b0, 0, 0);
    add(1'b0, 2'b11, 2, 0, 1'b0, 0, 0);
    add(1'b0, 2'b10, 2, 0, 1'b0, 0, 0);
    add(1'b0, 2'b00, 2, 1, 1'b1, 1, 0);

    foreach (tbl[i]) begin
      steps = 0;
      errs  = 0;
      for (int c = 0; c < tbl[i].hold; c++) begin
        drive(tbl[i].rst, tbl[i].ab);
        if (step_w[0] === 1'b1) steps++;
        if (err_w[0]  === 1'b1) errs++;
      end
      check($sformatf("seg%0d.value", i), 32'(val_w[0]), 32'(tbl[i].e_val));
      check($sformatf("seg%0d.dir", i),   32'(dir_w[0]), 32'(tbl[i].e_dir));
      check($sformatf("seg%0d.steps", i), 32'(steps),    32'(tbl[i].e_steps));
      check($sformatf("seg%0d.errs", i),  32'(errs),     32'(tbl[i].e_errs));
    end

    // Clamp / wrap limits: two forward, three reverse detents from reset.
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b00);
    drive(1'b0, 2'b00);
    for (int n = 0; n < 5; n++) begin
      if (n < 2) fwd(); else rev();
      check($sformatf("lim%0d.v0", n), 32'(val_w[0]), 32'(e_v0[n]));
      check($sformatf("lim%0d.v1", n), 32'(val_w[1]), 32'(e_v1[n]));
      check($sformatf("lim%0d.v2", n), 32'(val_w[2]), 32'(e_v2[n]));
      check($sformatf("lim%0d.p0", n), 32'(step_w[0]), 32'd1);
      check($sformatf("lim%0d.p1", n), 32'(step_w[1]), 32'd1);
      check($sformatf("lim%0d.d1", n), 32'(dir_w[1]),  (n < 2) ? 32'd1 : 32'd0);
    end

    // Randomized walk: mostly legal quarter steps, some holds, rare illegal
    // jumps and resets, all checked against the model every cycle.
    cur = 0;
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        drive(1'b1, ab_of(cur));
      end else begin
        if (r < 35)      cur = cur;
        else if (r < 66) cur = (cur + 1) % 4;
        else if (r < 95) cur = (cur + 3) % 4;
        else             cur = (cur + 2) % 4;
        drive(1'b0, ab_of(cur));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
